// File: rtl/ql_vram.sv
// ql_vram: QL screen memory with video read port, byte-wide CPU handshake port,
// display control register and full-bitmap clear engine.
module ql_vram #(
  parameter logic [15:0] CLEAR_VALUE = 16'h0000
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [13:0] vid_addr_i,
  output logic [15:0] vid_dout_o,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic        cpu_reg_i,
  input  logic [14:0] cpu_addr_i,
  input  logic [7:0]  cpu_din_i,
  output logic [7:0]  cpu_dout_o,
  output logic        cpu_ack_o,
  input  logic        clear_i,
  output logic        busy_o,
  output logic        mode_o,
  output logic        blank_o
);
  typedef enum logic [1:0] {IDLE, ACCESS, ACK, CLEAR} state_t;
  state_t      state_q, state_d;
  logic        pending_q, pending_d;
  logic [13:0] cnt_q;
  logic        we_q, reg_q, mode_q, blank_q;
  logic [14:0] addr_q;
  logic [7:0]  din_q, dout_q;
  logic [15:0] vid_q;
  logic [15:0] mem_q [16384];
  logic        mem_we;
  logic [1:0]  mem_be;
  logic [13:0] mem_wa;
  logic [15:0] mem_wd, rd_word;
  logic [7:0]  rd_byte, reg_val;
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = pending_q ? CLEAR : cpu_req_i ? ACCESS : IDLE;
      ACCESS:  state_d = ACK;
      ACK:     state_d = cpu_req_i ? ACK : IDLE;
      CLEAR:   state_d = (cnt_q == 14'h3fff) ? IDLE : CLEAR;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    cpu_ack_o = state_q == ACK;
    busy_o    = state_q == CLEAR;
    mem_we    = busy_o || (state_q == ACCESS && we_q && !reg_q);
    mem_wa    = busy_o ? cnt_q : addr_q[14:1];
    mem_wd    = busy_o ? CLEAR_VALUE : {din_q, din_q};
    mem_be    = busy_o ? 2'b11 : addr_q[0] ? 2'b01 : 2'b10;
  end
  // A clear pulse always wins over the consumption of the flag on entry to CLEAR.
  assign pending_d = clear_i || (pending_q && state_q != IDLE);
  assign rd_word   = mem_q[addr_q[14:1]];
  assign rd_byte   = addr_q[0] ? rd_word[7:0] : rd_word[15:8];
  assign reg_val   = {4'b0, mode_q, 1'b0, blank_q, 1'b0};
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      pending_q <= 1'b0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      reg_q     <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      dout_q    <= '0;
      mode_q    <= 1'b0;
      blank_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (state_q == IDLE && !pending_q && cpu_req_i) begin
        we_q   <= cpu_we_i;
        reg_q  <= cpu_reg_i;
        addr_q <= cpu_addr_i;
        din_q  <= cpu_din_i;
      end
      if (state_q == ACCESS && we_q && reg_q) begin
        mode_q  <= din_q[3];
        blank_q <= din_q[1];
      end
      if (state_q == ACCESS && !we_q) dout_q <= reg_q ? reg_val : rd_byte;
      if (busy_o) cnt_q <= cnt_q + 14'd1;
    end
  // Bitmap storage is deliberately outside the reset domain.
  always_ff @(posedge clk_i) begin
    if (mem_we && mem_be[1]) mem_q[mem_wa][15:8] <= mem_wd[15:8];
    if (mem_we && mem_be[0]) mem_q[mem_wa][7:0] <= mem_wd[7:0];
  end
  // Falling-edge latch gives scanout a half-cycle address-to-data path.
  always_ff @(negedge clk_i or negedge reset_n_i)
    if (!reset_n_i) vid_q <= '0;
    else vid_q <= mem_q[vid_addr_i];
  assign vid_dout_o = vid_q;
  assign cpu_dout_o = dout_q;
  assign mode_o     = mode_q;
  assign blank_o    = blank_q;
endmodule
